// File: rtl/dtable_tracker_if.sv
// Bus bundle between the MSP430 write-snoop / D-table memory side and dtable_tracker.
// master drives the write bus and snapshot request; slave is the tracker.
interface dtable_tracker_if #(
    parameter int unsigned TOTAL_BLOCKS = 16,
    parameter int unsigned CNT_W        = 5
);
    logic [15:0]             dmem_addr;
    logic                    dmem_wen;
    logic                    snap_req;
    logic                    snap_ack;
    logic                    busy;
    logic [TOTAL_BLOCKS-1:0] D_table_out;
    logic [CNT_W-1:0]        dirty_cnt;
    logic                    oor_wr;

    modport master (
        output dmem_addr, dmem_wen, snap_req,
        input  snap_ack, busy, D_table_out, dirty_cnt, oor_wr
    );

    modport slave (
        input  dmem_addr, dmem_wen, snap_req,
        output snap_ack, busy, D_table_out, dirty_cnt, oor_wr
    );
endinterface

// File: rtl/dtable_tracker.sv
// Dirty-block tracker for MSP430 DMEM: one bit per block, snapshot into D_table_out,
// then a one-block-per-cycle clearing sweep that keeps writes arriving mid-sweep.
module dtable_tracker #(
    parameter logic [15:0] DMEM_BASE = 16'h0200,
    parameter int unsigned DMEM_SIZE = 32'h0800,
    parameter int unsigned BLK_SIZE  = 128
) (
    input logic             mclk,
    input logic             puc_rst_n,
    dtable_tracker_if.slave bus
);
    localparam int unsigned BLK_MSB      = $clog2(BLK_SIZE);
    localparam int unsigned TOTAL_BLOCKS = DMEM_SIZE >> BLK_MSB;
    localparam int unsigned IDX_W        = $clog2(TOTAL_BLOCKS);
    localparam int unsigned CNT_W        = $clog2(TOTAL_BLOCKS + 1);
    localparam logic [15:0] DMEM_LAST    = 16'(32'(DMEM_BASE) + DMEM_SIZE - 32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BLOCKS - 1);

    typedef enum logic [1:0] {TRACK, SNAP, CLEAR, ACK} state_t;

    state_t                  state;
    logic [TOTAL_BLOCKS-1:0] live_map;
    logic [TOTAL_BLOCKS-1:0] fresh;
    logic [TOTAL_BLOCKS-1:0] d_table;
    logic [IDX_W-1:0]        sweep_idx;
    logic [CNT_W-1:0]        dirty_cnt;
    logic                    snap_ack;
    logic                    busy;
    logic                    oor_wr;

    logic [15:0]             offset;
    logic [IDX_W-1:0]        idx;
    logic                    hit;
    logic                    miss;
    logic [TOTAL_BLOCKS-1:0] hit_vec;
    logic [TOTAL_BLOCKS-1:0] clr_vec;
    logic                    cnt_inc;
    logic                    cnt_dec;

    // Decode the snooped write and the sweep's clear for this cycle; a set always beats a clear.
    always_comb begin
        offset  = bus.dmem_addr - DMEM_BASE;
        idx     = IDX_W'(offset >> BLK_MSB);
        hit     = bus.dmem_wen && (bus.dmem_addr >= DMEM_BASE) && (bus.dmem_addr <= DMEM_LAST);
        miss    = bus.dmem_wen && !hit;
        hit_vec = '0;
        if (hit) hit_vec[idx] = 1'b1;
        clr_vec = '0;
        if ((state == CLEAR) && !fresh[sweep_idx] && !hit_vec[sweep_idx])
            clr_vec[sweep_idx] = 1'b1;
        cnt_inc = hit && !live_map[idx];
        cnt_dec = |(clr_vec & live_map);
    end

    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state     <= TRACK;
            live_map  <= '0;
            fresh     <= '0;
            d_table   <= '0;
            sweep_idx <= '0;
            dirty_cnt <= '0;
            snap_ack  <= 1'b0;
            busy      <= 1'b0;
            oor_wr    <= 1'b0;
        end else begin
            live_map  <= (live_map | hit_vec) & ~clr_vec;
            dirty_cnt <= dirty_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
            case (state)
                TRACK: begin
                    if (bus.snap_req) begin
                        state <= SNAP;
                        busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    d_table   <= live_map | hit_vec;
                    fresh     <= '0;
                    sweep_idx <= '0;
                    oor_wr    <= 1'b0;
                    state     <= CLEAR;
                end
                CLEAR: begin
                    // fresh marks blocks written since the snapshot so the sweep skips them
                    fresh     <= fresh | hit_vec;
                    sweep_idx <= sweep_idx + IDX_W'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state    <= ACK;
                        busy     <= 1'b0;
                        snap_ack <= 1'b1;
                    end
                end
                ACK: begin
                    if (!bus.snap_req) begin
                        state    <= TRACK;
                        snap_ack <= 1'b0;
                    end
                end
                default: state <= TRACK;
            endcase
            if (miss) oor_wr <= 1'b1;
        end
    end

    assign bus.D_table_out = d_table;
    assign bus.dirty_cnt   = dirty_cnt;
    assign bus.snap_ack    = snap_ack;
    assign bus.busy        = busy;
    assign bus.oor_wr      = oor_wr;
endmodule

// File: tb/tb_dtable_tracker.sv
// Self-checking bench for dtable_tracker: directed scenarios plus randomized traffic
// compared against a block-level behavioural model.
module tb_dtable_tracker;
    localparam int P_TRACK = 0;
    localparam int P_SNAP  = 1;
    localparam int P_CLEAR = 2;
    localparam int P_ACK   = 3;

    logic mclk;
    logic rst_n;
    dtable_tracker_if bus ();

    dtable_tracker dut (
        .mclk      (mclk),
        .puc_rst_n (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model
    logic [15:0] m_live;
    logic [15:0] m_fresh;
    logic [15:0] m_dtab;
    logic        m_oor;
    int          m_phase;
    int          m_k;

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic model_edge();
        int a;
        int idx;
        bit hit;
        a   = int'(bus.dmem_addr);
        hit = bus.dmem_wen && (a >= 'h200) && (a <= 'h200 + 'h800 - 1);
        idx = (a - 'h200) / 128;
        if (!rst_n) begin
            m_live = '0; m_fresh = '0; m_dtab = '0; m_oor = 1'b0;
            m_phase = P_TRACK; m_k = 0;
            return;
        end
        case (m_phase)
            P_TRACK: if (bus.snap_req) m_phase = P_SNAP;
            P_SNAP: begin
                m_dtab = m_live;
                if (hit) m_dtab[idx] = 1'b1;
                m_oor = 1'b0; m_fresh = '0; m_k = 0;
                m_phase = P_CLEAR;
            end
            P_CLEAR: begin
                if (hit) m_fresh[idx] = 1'b1;
                if (!m_fresh[m_k]) m_live[m_k] = 1'b0;
                m_k++;
                if (m_k == 16) m_phase = P_ACK;
            end
            default: if (!bus.snap_req) m_phase = P_TRACK;
        endcase
        if (hit) m_live[idx] = 1'b1;
        if (bus.dmem_wen && !hit) m_oor = 1'b1;
    endtask

    task automatic tick();
        @(posedge mclk);
        model_edge();
        #1;
    endtask

    task automatic write_cycle(input logic [15:0] addr);
        bus.dmem_addr = addr;
        bus.dmem_wen  = 1'b1;
        tick();
        bus.dmem_wen  = 1'b0;
    endtask

    // full request/ack handshake; returns with snap_req low and tracker back in TRACK
    task automatic do_snapshot();
        bus.snap_req = 1'b1;
        for (int i = 0; i < 40 && m_phase != P_ACK; i++) tick();
        bus.snap_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.dmem_addr = '0; bus.dmem_wen = 1'b0; bus.snap_req = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.D_table_out, 5'(bus.dirty_cnt), bus.snap_ack, bus.busy, bus.oor_wr} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got dtab=%h cnt=%0d ack=%b busy=%b oor=%b, expected all 0",
                     bus.D_table_out, bus.dirty_cnt, bus.snap_ack, bus.busy, bus.oor_wr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_boundary_writes();
        write_cycle(16'h0200);
        write_cycle(16'h027F);
        write_cycle(16'h0280);
        write_cycle(16'h09FF);
        n_checks++;
        if (bus.dirty_cnt !== 5'd3) begin
            n_errors++;
            $display("FAIL boundary_cnt: got %0d expected 3", bus.dirty_cnt);
        end
        n_checks++;
        if (bus.oor_wr !== 1'b0) begin
            n_errors++;
            $display("FAIL boundary_oor: got %b expected 0", bus.oor_wr);
        end
        do_snapshot();
        n_checks++;
        if (bus.D_table_out !== 16'h8003) begin
            n_errors++;
            $display("FAIL boundary_dtab: got %h expected 8003", bus.D_table_out);
        end
    endtask

    task automatic test_out_of_range();
        write_cycle(16'h01FF);
        write_cycle(16'h0A00);
        n_checks++;
        if (bus.oor_wr !== 1'b1 || bus.dirty_cnt !== 5'd0) begin
            n_errors++;
            $display("FAIL oor_set: got oor=%b cnt=%0d expected oor=1 cnt=0", bus.oor_wr, bus.dirty_cnt);
        end
        do_snapshot();
        n_checks++;
        if (bus.oor_wr !== 1'b0 || bus.D_table_out !== 16'h0000) begin
            n_errors++;
            $display("FAIL oor_clear: got oor=%b dtab=%h expected oor=0 dtab=0000", bus.oor_wr, bus.D_table_out);
        end
    endtask

    task automatic test_snapshot();
        int busy_cycles;
        bit done;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        write_cycle(16'h0300);
        write_cycle(16'h0480);
        bus.snap_req = 1'b1;
        tick();
        busy_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.snap_ack === 1'b1) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL snap_timeout: snap_ack never rose within 40 cycles");
        end
        n_checks++;
        if (busy_cycles != 17) begin
            n_errors++;
            $display("FAIL snap_busy_len: got %0d cycles expected 17", busy_cycles);
        end
        n_checks++;
        if (bus.D_table_out !== 16'h0024 || bus.dirty_cnt !== 5'd0) begin
            n_errors++;
            $display("FAIL snap_result: got dtab=%h cnt=%0d expected dtab=0024 cnt=0", bus.D_table_out, bus.dirty_cnt);
        end
        tick();
        n_checks++;
        if (bus.snap_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL snap_ack_hold: got %b expected 1 while req high", bus.snap_ack);
        end
        bus.snap_req = 1'b0;
        tick();
        n_checks++;
        if (bus.snap_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL snap_ack_drop: got %b expected 0", bus.snap_ack);
        end
    endtask

    task automatic test_sweep_writes();
        write_cycle(16'h0500);
        bus.snap_req = 1'b1;
        for (int i = 0; i < 40 && !(m_phase == P_CLEAR && m_k == 3); i++) tick();
        n_checks++;
        if (bus.D_table_out !== 16'h0040) begin
            n_errors++;
            $display("FAIL sweep_dtab_snap: got %h expected 0040", bus.D_table_out);
        end
        bus.snap_req = 1'b0;  // dropping mid-sweep must not abort it
        write_cycle(16'h0380);
        write_cycle(16'h0900);
        for (int i = 0; i < 40 && m_phase != P_ACK; i++) tick();
        n_checks++;
        if (bus.snap_ack !== 1'b1 || bus.dirty_cnt !== 5'd2) begin
            n_errors++;
            $display("FAIL sweep_keep: got ack=%b cnt=%0d expected ack=1 cnt=2", bus.snap_ack, bus.dirty_cnt);
        end
        n_checks++;
        if (bus.D_table_out !== 16'h0040) begin
            n_errors++;
            $display("FAIL sweep_dtab_stable: got %h expected 0040", bus.D_table_out);
        end
        tick();
    endtask

    task automatic test_same_cycle_snap();
        bus.dmem_addr = 16'h0400;
        bus.dmem_wen  = 1'b1;
        bus.snap_req  = 1'b1;
        tick();
        bus.dmem_wen  = 1'b0;
        tick();
        n_checks++;
        if (bus.D_table_out !== 16'h4018) begin
            n_errors++;
            $display("FAIL same_cycle_dtab: got %h expected 4018", bus.D_table_out);
        end
        for (int i = 0; i < 40 && m_phase != P_ACK; i++) tick();
        n_checks++;
        if (bus.dirty_cnt !== 5'd0) begin
            n_errors++;
            $display("FAIL same_cycle_cnt: got %0d expected 0", bus.dirty_cnt);
        end
        bus.snap_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        write_cycle(16'h0780);
        bus.snap_req = 1'b1;
        for (int i = 0; i < 40 && !(m_phase == P_CLEAR && m_k == 7); i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({bus.D_table_out, 5'(bus.dirty_cnt), bus.snap_ack, bus.busy, bus.oor_wr} !== 24'h0) begin
            n_errors++;
            $display("FAIL midsweep_reset: got dtab=%h cnt=%0d ack=%b busy=%b oor=%b, expected all 0",
                     bus.D_table_out, bus.dirty_cnt, bus.snap_ack, bus.busy, bus.oor_wr);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midsweep_restart: got busy=%b expected 1", bus.busy);
        end
        for (int i = 0; i < 40 && m_phase != P_ACK; i++) tick();
        bus.snap_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.dmem_wen  = 1'($urandom_range(0, 1));
            bus.dmem_addr = 16'($urandom_range(32'h01C0, 32'h0A40));
            if ($urandom_range(0, 7) == 0) bus.snap_req = ~bus.snap_req;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
            n_checks++;
            if (bus.D_table_out !== m_dtab || int'(bus.dirty_cnt) != $countones(m_live) ||
                bus.busy !== (m_phase == P_SNAP || m_phase == P_CLEAR) ||
                bus.snap_ack !== (m_phase == P_ACK) || bus.oor_wr !== m_oor) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got dtab=%h cnt=%0d busy=%b ack=%b oor=%b expected dtab=%h cnt=%0d busy=%b ack=%b oor=%b",
                         c, bus.D_table_out, bus.dirty_cnt, bus.busy, bus.snap_ack, bus.oor_wr,
                         m_dtab, $countones(m_live), (m_phase == P_SNAP || m_phase == P_CLEAR),
                         (m_phase == P_ACK), m_oor);
            end
        end
        rst_n = 1'b1;
        bus.dmem_wen = 1'b0;
        bus.snap_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boundary_writes();
        test_out_of_range();
        test_snapshot();
        test_sweep_writes();
        test_same_cycle_snap();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dtable_tracker.md
Name: dtable_tracker

Overview:
- Upstream producer of the D-table bitmap.
- Snoops the MSP430 data-memory write bus and sets one dirty bit per BLK_SIZE-byte block of DMEM that the CPU writes.
- On a req/ack snapshot handshake, it freezes the bitmap into D_table_out for the D-table peripheral memory to expose to software. It then clears the live bitmap with a one-block-per-cycle sweep, without losing writes that arrive during the sweep.

Parameters:
DMEM_BASE, 16'h0200, byte base address of data memory
DMEM_SIZE, 16'h0800, data memory size in bytes; multiple of BLK_SIZE
BLK_SIZE, 128, tracking granularity in bytes; power of two
BLK_MSB, $clog2(BLK_SIZE), address shift for block index
TOTAL_BLOCKS, DMEM_SIZE >> BLK_MSB, number of tracked blocks (16 by default)
IDX_W, $clog2(TOTAL_BLOCKS), block index width
CNT_W, $clog2(TOTAL_BLOCKS+1), dirty counter width

Ports:
mclk  in  1  main system clock
puc_rst_n  in  1  synchronous active-low reset
dmem_addr  in  16  byte address of CPU data write
dmem_wen  in  1  write strobe, one cycle per write
snap_req  in  1  snapshot request (4-phase level)
snap_ack  out  1  snapshot complete, held until snap_req low
busy  out  1  high in SNAP/CLEAR states
D_table_out  out  TOTAL_BLOCKS  frozen bitmap for D-table memory, bit i = block i
dirty_cnt  out  CNT_W  number of set bits in live bitmap
oor_wr  out  1  sticky: write seen outside DMEM range; cleared by snapshot

Behaviour:
- Reset: all of the following are driven low on the first mclk edge with puc_rst_n=0, overriding any operation in progress including a mid-sweep: live_map=0, fresh=0, D_table_out=0, dirty_cnt=0, snap_ack=0, busy=0, oor_wr=0, sweep_idx=0, state=TRACK.
- Hit detect: hit = dmem_wen & (dmem_addr >= DMEM_BASE) & (dmem_addr <= DMEM_BASE+DMEM_SIZE-1).
- Block index: idx = (dmem_addr - DMEM_BASE) >> BLK_MSB, truncated to IDX_W.
- Miss handling: dmem_wen & ~hit sets oor_wr.
- Write latency: live_map[idx] <= 1 on the edge after the write cycle. This happens in every state.
- dirty_cnt: maintained incrementally, never recomputed. +1 when a hit sets a bit that was 0. -1 when the sweep clears a bit that was 1. Set and clear of different bits in the same cycle gives a net 0. It never exceeds TOTAL_BLOCKS and never underflows.
- FSM states: TRACK, SNAP, CLEAR, ACK.
- TRACK:
  - busy=0, snap_ack=0.
  - When snap_req=1, go to SNAP.
- SNAP (1 cycle):
  - D_table_out <= live_map, OR'd with the same-cycle hit bit so the write is included.
  - fresh <= 0, sweep_idx <= 0, oor_wr <= 0. A same-cycle miss still sets oor_wr, because set has priority.
  - Next state: CLEAR.
- CLEAR:
  - Each cycle, clear live_map[sweep_idx] unless fresh[sweep_idx]=1 or a hit targets sweep_idx this cycle. In both exceptions, set wins.
  - Any hit during CLEAR sets both live_map[idx] and fresh[idx].
  - sweep_idx increments each cycle. After sweep_idx = TOTAL_BLOCKS-1, go to ACK. CLEAR lasts exactly TOTAL_BLOCKS cycles.
- ACK:
  - busy=0, snap_ack=1.
  - Stay until snap_req=0, then go to TRACK with snap_ack=0 the next cycle.
- snap_req behaviour:
  - Dropping snap_req during SNAP or CLEAR has no effect; the sweep always completes.
  - ACK still exits the cycle after it sees snap_req=0.
- D_table_out is updated only in SNAP and is stable at all other times.
- Boundary addresses:
  - DMEM_BASE maps to block 0.
  - DMEM_BASE+DMEM_SIZE-1 maps to block TOTAL_BLOCKS-1.
  - DMEM_BASE-1 and DMEM_BASE+DMEM_SIZE are misses.
  - There is no wrap-around of idx.
- Repeated writes to an already-dirty block do not change dirty_cnt.

Test Plan:
1. Reset, then write 0x0200, 0x027F, 0x0280, 0x09FF -> live bits 0, 0, 1, 15 set; dirty_cnt=3; oor_wr=0.
2. Write 0x01FF, then 0x0A00 -> no bit set, oor_wr=1; a later snapshot clears oor_wr.
3. Blocks {2,5} dirty, raise snap_req -> D_table_out=16'h0024; busy high for exactly 17 cycles (SNAP + 16 CLEAR); snap_ack=1; dirty_cnt=0; drop snap_req -> snap_ack low next cycle.
4. During CLEAR at sweep_idx=3, write 0x0900 (block 14) and 0x0380 (block 3) -> both survive the sweep; dirty_cnt=2 at ACK; D_table_out unchanged from its SNAP value.
5. Write 0x0400 (block 4) in the same cycle snap_req is first seen in TRACK -> write lands in live_map; next-cycle SNAP captures bit 4 in D_table_out, then the sweep clears it; dirty_cnt=0.
6. Assert puc_rst_n=0 for one cycle at sweep_idx=7 -> every output 0 and state TRACK the next cycle; snap_req held high restarts SNAP on the following cycle.
